// File: rtl/pe_seq_ctrl.sv
// Tile sequencer for a row of unary-rate PEs: clear, weight load, cfg_k MAC
// windows of L bitstream cycles, then a fixed drain before signalling done.
module pe_seq_ctrl #(
  parameter int IWIDTH = 8,
  parameter int KWIDTH = 16,
  parameter int DRAIN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [IWIDTH-2:0] cfg_len,
  input  logic [KWIDTH-1:0] cfg_k,
  output logic              busy,
  output logic              done,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              mac_done
);

  localparam int LW = IWIDTH - 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     cyc_q, cyc_d;
  logic [KWIDTH-1:0] win_q, win_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic [KWIDTH-1:0] k_q, k_d;
  logic [LW-1:0]     last_cyc_q, last_cyc_d;

  // cfg_len==0 encodes full length; len-1 then wraps naturally to all-ones.
  assign last_cyc_q = len_q - LW'(1);
  assign last_cyc_d = len_d - LW'(1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    win_d   = win_q;
    dcnt_d  = dcnt_q;
    len_d   = len_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          len_d   = cfg_len;
          k_d     = cfg_k;
        end
      end
      S_CLEAR: begin
        dcnt_d  = '0;
        state_d = (k_q == '0) ? S_DRAIN : S_LOAD_W;
      end
      S_LOAD_W: begin
        state_d = S_RUN;
        cyc_d   = '0;
        win_d   = '0;
      end
      S_RUN: begin
        if (cyc_q == last_cyc_q) begin
          cyc_d = '0;
          win_d = win_q + KWIDTH'(1);
          if (win_q == k_q - KWIDTH'(1)) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end
        end else begin
          cyc_d = cyc_q + LW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(DRAIN - 1)) state_d = S_DONE;
        else                          dcnt_d  = dcnt_q + DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs are registered by decoding the next state, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      win_q    <= '0;
      dcnt_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      en_i     <= 1'b0;
      clr_i    <= 1'b0;
      en_w     <= 1'b0;
      clr_w    <= 1'b0;
      en_o     <= 1'b0;
      clr_o    <= 1'b0;
      mac_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      win_q    <= win_d;
      dcnt_q   <= dcnt_d;
      len_q    <= len_d;
      k_q      <= k_d;
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      en_i     <= (state_d == S_RUN) && (cyc_d == '0);
      clr_i    <= (state_d == S_CLEAR);
      en_w     <= (state_d == S_LOAD_W);
      clr_w    <= (state_d == S_CLEAR);
      en_o     <= (state_d == S_RUN);
      clr_o    <= (state_d == S_CLEAR);
      mac_done <= (state_d == S_RUN) && (cyc_d == last_cyc_d);
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: a tile-offset timing model predicts every
// output cycle; a monitor compares the registered outputs against the queue.
module tb_pe_seq_ctrl;

  localparam int IWIDTH = 8;
  localparam int KWIDTH = 16;
  localparam int DRAIN  = 4;
  localparam int FULL   = 1 << (IWIDTH - 1);

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [IWIDTH-2:0] cfg_len;
  logic [KWIDTH-1:0] cfg_k;
  logic busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done;

  pe_seq_ctrl #(.IWIDTH(IWIDTH), .KWIDTH(KWIDTH), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_k(cfg_k),
    .busy(busy), .done(done), .en_i(en_i), .clr_i(clr_i), .en_w(en_w),
    .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o), .mac_done(mac_done)
  );

  always #5 clk = ~clk;

  // {busy,done,en_i,clr_i,en_w,clr_w,en_o,clr_o,mac_done}
  logic [8:0] sb[$];
  int tests  = 0;
  int errors = 0;

  // reference model state: accepted tile start cycle and its latched config
  int  cyc = 0;
  bit  act = 0;
  int  t0  = 0;
  int  mL  = 1;
  int  mk  = 0;

  function automatic int done_off(input int L, input int k);
    return (k == 0) ? 2 + DRAIN : 3 + k * L + DRAIN;
  endfunction

  // Expected outputs at a given cycle offset from the accepted start.
  function automatic logic [8:0] expect_at(input int off, input int L, input int k);
    logic [8:0] v;
    int r;
    v = '0;
    if (off < 1 || off > done_off(L, k)) return v;
    v[8] = 1'b1;
    v[7] = (off == done_off(L, k));
    if (off == 1) begin
      v[5] = 1'b1; v[3] = 1'b1; v[1] = 1'b1;
    end
    if (k > 0) begin
      v[4] = (off == 2);
      if (off >= 3 && off < 3 + k * L) begin
        r    = (off - 3) % L;
        v[2] = 1'b1;
        v[6] = (r == 0);
        v[0] = (r == L - 1);
      end
    end
    return v;
  endfunction

  task automatic tick(input bit r, input bit s, input bit a,
                      input int len, input int k);
    bit busy_now;
    @(negedge clk);
    rst = r; start = s; abort = a;
    cfg_len = (IWIDTH-1)'(len);
    cfg_k   = KWIDTH'(k);
    busy_now = act && (cyc - t0) >= 1 && (cyc - t0) <= done_off(mL, mk);
    if (r) act = 0;
    else if (busy_now) begin
      if (a) act = 0;
    end else if (s) begin
      act = 1; t0 = cyc;
      mL  = (len % FULL == 0) ? FULL : len % FULL;
      mk  = k;
    end else act = 0;
    sb.push_back(act ? expect_at(cyc + 1 - t0, mL, mk) : 9'b0);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    logic [8:0] got, exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        got   = {busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done};
        tests++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle=%0d got=%b exp=%b (busy,done,en_i,clr_i,en_w,clr_w,en_o,clr_o,mac_done)",
                   cyc, got, exp_v);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_len = '0; cfg_k = '0;
    // reset held, then idle
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
    idle(10);
    // L=4, k=3 baseline
    tick(0, 1, 0, 4, 3); idle(25);
    // full length window
    tick(0, 1, 0, 0, 1); idle(140);
    // zero windows
    tick(0, 1, 0, 5, 0); idle(10);
    // abort during RUN, then a clean tile
    tick(0, 1, 0, 4, 3); idle(7);
    tick(0, 0, 1, 0, 0); idle(3);
    tick(0, 1, 0, 4, 3); idle(25);
    // abort in idle does nothing
    tick(0, 0, 1, 0, 0); idle(2);
    // start re-pulse and cfg change mid-tile are ignored
    tick(0, 1, 0, 4, 3); idle(4);
    tick(0, 1, 0, 7, 9); tick(0, 0, 0, 7, 9); tick(0, 1, 0, 1, 1); idle(20);
    // L=1: en_i and mac_done together every RUN cycle
    tick(0, 1, 0, 1, 2); idle(12);
    // start on the done cycle is ignored, next cycle accepted
    tick(0, 1, 0, 2, 1); idle(8);
    tick(0, 1, 0, 2, 1); tick(0, 1, 0, 3, 1); idle(15);
    // reset mid-tile
    tick(0, 1, 0, 3, 2); idle(4);
    tick(1, 0, 0, 0, 0); idle(5);
    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int len, k;
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      k   = $urandom_range(0, 4);
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0, len, k);
    end
    idle(3);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d entries left, exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
